// File: rtl/golomb_dec.sv
// Serial Golomb-Rice decoder: one code bit per cycle in, one 9-bit Merrval out.
// Define GOLOMB_DEC_LIMIT_CHECK_EN to flag malformed codes (over-long zero runs, limit<10) on err.
module golomb_dec (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic [4:0] i_k,
   input  logic [5:0] i_limit,
   input  logic       i_bit_in,
   input  logic       i_bit_valid,
   output logic       o_bit_ready,
   output logic [8:0] o_merrval,
   output logic       o_val_out,
   input  logic       i_dout_ready,
   output logic       o_busy,
   output logic       o_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNARY,
      S_REM,
      S_ESC,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [4:0] r_kq;
   logic [5:0] r_lim9q;
   logic [5:0] r_zcnt;
   logic [4:0] r_bcnt;
   logic [8:0] r_acc;
   logic       r_err;
   logic       w_xfer;

   assign w_xfer      = i_bit_valid && o_bit_ready;
   assign o_bit_ready = (r_state == S_UNARY) || (r_state == S_REM) ||
                        (r_state == S_ESC);
   assign o_val_out   = (r_state == S_DONE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_merrval   = r_acc;
   assign o_err       = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_kq    <= '0;
         r_lim9q <= '0;
         r_zcnt  <= '0;
         r_bcnt  <= '0;
         r_acc   <= '0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_kq    <= i_k;
                  r_lim9q <= i_limit - 6'd9;
                  r_zcnt  <= '0;
                  r_acc   <= '0;
                  r_err   <= 1'b0;
`ifdef GOLOMB_DEC_LIMIT_CHECK_EN
                  if (i_limit < 6'd10) begin
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_UNARY;
                  end
`else
                  r_state <= S_UNARY;
`endif
               end
            end
            S_UNARY: begin
               if (w_xfer) begin
                  if (!i_bit_in) begin
`ifdef GOLOMB_DEC_LIMIT_CHECK_EN
                     if (r_zcnt == r_lim9q) begin
                        r_err   <= 1'b1;
                        r_acc   <= '0;
                        r_state <= S_DONE;
                     end else if (r_zcnt != 6'd63) begin
                        r_zcnt <= r_zcnt + 6'd1;
                     end
`else
                     if (r_zcnt != 6'd63) begin
                        r_zcnt <= r_zcnt + 6'd1;
                     end
`endif
                  end else if (r_zcnt < r_lim9q) begin
                     r_acc   <= {3'b000, r_zcnt};
                     r_bcnt  <= r_kq;
                     r_state <= (r_kq == 5'd0) ? S_DONE : S_REM;
                  end else begin
                     // Run reached the limit: a raw 8-bit escape value follows
                     r_acc   <= '0;
                     r_bcnt  <= 5'd8;
                     r_state <= S_ESC;
                  end
               end
            end
            S_REM: begin
               if (w_xfer) begin
                  r_acc  <= {r_acc[7:0], i_bit_in};
                  r_bcnt <= r_bcnt - 5'd1;
                  if (r_bcnt == 5'd1) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_ESC: begin
               if (w_xfer) begin
                  r_bcnt <= r_bcnt - 5'd1;
                  if (r_bcnt == 5'd1) begin
                     r_acc   <= {1'b0, r_acc[6:0], i_bit_in} + 9'd1;
                     r_state <= S_DONE;
                  end else begin
                     r_acc <= {r_acc[7:0], i_bit_in};
                  end
               end
            end
            S_DONE: begin
               if (i_dout_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_golomb_dec.sv
// Bench for golomb_dec: directed code words plus random symbols
// checked against a bit-string level Golomb-Rice decode model.
module tb_golomb_dec;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       i_start = 1'b0;
   logic [4:0] i_k = '0;
   logic [5:0] i_limit = '0;
   logic       i_bit_in = 1'b0;
   logic       i_bit_valid = 1'b0;
   logic       o_bit_ready;
   logic [8:0] o_merrval;
   logic       o_val_out;
   logic       i_dout_ready = 1'b0;
   logic       o_busy;
   logic       o_err;

   int errors = 0;
   int checks = 0;
   int tot_xfer = 0;
   int base = 0;
   int exp_val = 0;
   int exp_n = 0;
   bit exp_err = 1'b0;
   bit chk_en = 1'b0;
   bit bq[$];

   always #5 clk = ~clk;

   golomb_dec dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (i_start),
      .i_k          (i_k),
      .i_limit      (i_limit),
      .i_bit_in     (i_bit_in),
      .i_bit_valid  (i_bit_valid),
      .o_bit_ready  (o_bit_ready),
      .o_merrval    (o_merrval),
      .o_val_out    (o_val_out),
      .i_dout_ready (i_dout_ready),
      .o_busy       (o_busy),
      .o_err        (o_err)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Decode the code word at the head of bq straight from the Golomb rules
   task automatic model(input int k, input int lim);
      int lim9;
      int z;
      int zs;
      lim9 = (lim - 9) & 63;
      exp_err = 1'b0;
      exp_val = 0;
      exp_n = 0;
`ifdef GOLOMB_DEC_LIMIT_CHECK_EN
      if (lim < 10) begin
         exp_err = 1'b1;
         return;
      end
`endif
      z = 0;
      while (z < bq.size() && bq[z] == 1'b0) z++;
`ifdef GOLOMB_DEC_LIMIT_CHECK_EN
      if (z > lim9) begin
         exp_err = 1'b1;
         exp_n = lim9 + 1;
         return;
      end
`endif
      zs = (z > 63) ? 63 : z;
      if (zs < lim9) begin
         exp_val = zs;
         for (int i = 0; i < k; i++)
            exp_val = ((exp_val << 1) | int'(bq[z + 1 + i])) & 511;
         exp_n = z + 1 + k;
      end else begin
         for (int i = 0; i < 8; i++)
            exp_val = (exp_val << 1) | int'(bq[z + 1 + i]);
         exp_val = exp_val + 1;
         exp_n = z + 9;
      end
   endtask

   task automatic add_bits(input int v, input int w);
      for (int i = w - 1; i >= 0; i--) bq.push_back(bit'((v >> i) & 1));
   endtask

   task automatic add_zeros(input int n);
      for (int i = 0; i < n; i++) bq.push_back(1'b0);
   endtask

   always @(posedge clk)
      if (reset && i_bit_valid && o_bit_ready) tot_xfer++;

   // Compare process: DUT outputs against the model every cycle
   always @(negedge clk) begin
      if (reset && chk_en) begin
         chk("bit_ready_vs_phase", int'(o_bit_ready),
             int'(o_busy && !o_val_out));
         if (o_val_out) begin
            chk("merrval", int'(o_merrval), exp_val);
            chk("err", int'(o_err), int'(exp_err));
            chk("bits_consumed", tot_xfer - base, exp_n);
            chk("busy_in_done", int'(o_busy), 1);
         end
      end
   end

   task automatic run_sym(input int k, input int lim, input int vmode,
                          input int rdly, output int lat);
      int cyc;
      bit v;
      model(k, lim);
      cyc = 0;
      while (o_busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      i_k = k[4:0];
      i_limit = lim[5:0];
      i_start = 1'b1;
      base = tot_xfer;
      @(negedge clk);
      i_start = 1'b0;
      lat = 1;
      if (exp_n > 0) chk("ready_after_start", int'(o_bit_ready), 1);
      while (!o_val_out && lat < 400) begin
         if (vmode == 0) v = 1'b1;
         else if (vmode == 1) v = lat[0];
         else v = 1'($urandom_range(0, 1));
         i_bit_valid = v;
         i_bit_in = bq[tot_xfer - base];
         @(negedge clk);
         lat++;
      end
      if (!o_val_out) chk("timeout_val_out", 0, 1);
      i_bit_valid = 1'b1;
      i_bit_in = bq[tot_xfer - base];
      repeat (rdly) @(negedge clk);
      i_dout_ready = 1'b1;
      @(negedge clk);
      i_dout_ready = 1'b0;
      i_bit_valid = 1'b0;
      chk("idle_after_handshake", int'(o_busy), 0);
   endtask

   initial begin
      int lat;
      int k;
      int lim;
      int lim9;
      int z;

      repeat (3) @(negedge clk);
      chk("rst_bit_ready", int'(o_bit_ready), 0);
      chk("rst_val_out", int'(o_val_out), 0);
      chk("rst_merrval", int'(o_merrval), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_err", int'(o_err), 0);
      reset = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      bq.delete(); add_bits(5'b00110, 5);
      run_sym(2, 23, 0, 0, lat);
      chk("pin_k2_val", exp_val, 10);
      chk("lat_k2", lat, 6);

      bq.delete(); add_bits(1, 1);
      run_sym(0, 23, 0, 0, lat);
      chk("pin_k0_val", exp_val, 0);
      chk("lat_min", lat, 2);

      bq.delete(); add_bits(4'b0001, 4);
      run_sym(0, 23, 0, 0, lat);
      chk("pin_k0_z3", exp_val, 3);

      bq.delete(); add_zeros(14); add_bits(1, 1); add_bits(8'h2C, 8);
      run_sym(2, 23, 0, 0, lat);
      chk("pin_esc_val", exp_val, 45);
      chk("pin_esc_len", exp_n, 23);

      bq.delete(); add_zeros(14); add_bits(1, 1); add_bits(8'hFF, 8);
      run_sym(2, 23, 0, 1, lat);
      chk("pin_esc_ff", exp_val, 256);

      bq.delete(); add_bits(5'b00110, 5); add_bits(8'hA5, 8);
      run_sym(2, 23, 1, 4, lat);
      chk("pin_stall_val", exp_val, 10);

      i_k = 5'd3;
      i_limit = 6'd23;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_bit_valid = 1'b1;
      i_bit_in = 1'b1;
      @(negedge clk);
      i_bit_in = 1'b0;
      @(negedge clk);
      chk("busy_before_abort", int'(o_busy), 1);
      reset = 1'b0;
      i_bit_valid = 1'b0;
      #1;
      chk("abort_bit_ready", int'(o_bit_ready), 0);
      chk("abort_val_out", int'(o_val_out), 0);
      chk("abort_merrval", int'(o_merrval), 0);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_err", int'(o_err), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bq.delete(); add_bits(4'b1101, 4);
      run_sym(3, 23, 0, 0, lat);
      chk("pin_after_abort", exp_val, 5);

`ifdef GOLOMB_DEC_LIMIT_CHECK_EN
      bq.delete(); add_zeros(15); add_bits(1, 1);
      run_sym(2, 23, 0, 0, lat);
      chk("pin_long_err", int'(exp_err), 1);
      chk("pin_long_len", exp_n, 15);
      bq.delete(); add_bits(1, 1);
      run_sym(2, 8, 0, 0, lat);
      chk("pin_lim8_err", int'(exp_err), 1);
      chk("lat_lim8", lat, 1);
`endif

      repeat (300) begin
         if ($urandom_range(0, 9) == 0) k = $urandom_range(9, 31);
         else k = $urandom_range(0, 8);
         lim = $urandom_range(10, 63);
`ifdef GOLOMB_DEC_LIMIT_CHECK_EN
         if ($urandom_range(0, 9) == 0) lim = $urandom_range(0, 9);
`endif
         lim9 = (lim - 9) & 63;
         if ($urandom_range(0, 19) == 0) z = $urandom_range(60, 70);
         else if ($urandom_range(0, 3) == 0) z = $urandom_range(lim9, lim9 + 3);
         else z = $urandom_range(0, (lim9 > 0) ? lim9 - 1 : 0);
         bq.delete();
         add_zeros(z);
         add_bits(1, 1);
         repeat (40) bq.push_back(1'($urandom_range(0, 1)));
         run_sym(k, lim, 2, $urandom_range(0, 3), lat);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
